opb_event_counter_bank: RTL and testbench

Parametrised bank of N_CH event counters readable and controllable over OPB, the multi-channel successor to the single 32-bit simulink-to-PPC status register used for per-port counters such as 10GbE bad-frame counts. Sits on the OPB as a slave beside the gbe cores. Counts single-cycle or level event strobes, supports wrap or saturate mode, sticky overflow flags, per-channel clear and an atomic snapshot of all channels.

---
 rtl/opb_event_counter_bank.sv | 168 ++++++++++++++++
 tb/tb_opb_event_counter_bank.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/opb_event_counter_bank.sv
// OPB slave holding N_CH event counters (wrap or saturate), sticky overflow flags and per-channel clear.
// Optional per-channel snapshot bank is built when OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN is defined.
module opb_event_counter_bank #(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter int          N_CH         = 4,
  parameter int          CNT_W        = 32,
  parameter int          SATURATE     = 0
) (
  input  logic                    OPB_Clk,
  input  logic                    OPB_Rst_n,
  input  logic [0:C_OPB_AWIDTH-1] OPB_ABus,
  input  logic [0:3]              OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1] OPB_DBus,
  input  logic                    OPB_RNW,
  input  logic                    OPB_select,
  input  logic                    OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1] Sl_DBus,
  output logic                    Sl_xferAck,
  output logic                    Sl_errAck,
  output logic                    Sl_retry,
  output logic                    Sl_toutSup,
  input  logic [N_CH-1:0]         event_in,
  output logic [N_CH-1:0]         ovf_out
);

  localparam int WD_W = (N_CH > 2) ? N_CH : 2;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [31:0]      w_addr;
  logic [31:0]      w_wdata;
  logic [32:0]      w_sub;
  logic [29:0]      w_off;
  logic [31:0]      w_rd_mux;
  logic             w_hit;
  logic             w_wr;
  logic             w_ctrl_wr;
  logic             w_ovf_wr;
  logic             w_snap_valid;
  logic             w_unused;
  logic [CNT_W-1:0] w_chval [N_CH];

  logic             r_hit;
  logic             r_ack;
  logic             r_rnw;
  logic [29:0]      r_off;
  logic [WD_W-1:0]  r_wdata;
  logic [31:0]      r_rdata;

  genvar gi;

  assign w_addr  = OPB_ABus;
  assign w_wdata = OPB_DBus;
  // 33-bit subtract gives the below-base flag as the borrow bit
  assign w_sub   = {1'b0, w_addr} - {1'b0, C_BASEADDR};
  assign w_off   = w_sub[31:2];
  assign w_hit   = OPB_select && !w_sub[32] && (w_addr <= C_HIGHADDR);
  assign w_unused = &{1'b0, OPB_BE, OPB_seqAddr, w_wdata, w_sub[1:0]};

  assign Sl_xferAck = r_hit & ~r_ack;
  assign Sl_DBus    = Sl_xferAck ? r_rdata : '0;
  assign Sl_errAck  = 1'b0;
  assign Sl_retry   = 1'b0;
  assign Sl_toutSup = 1'b0;

  assign w_wr      = Sl_xferAck & ~r_rnw;
  assign w_ctrl_wr = w_wr && (r_off == 30'd0);
  assign w_ovf_wr  = w_wr && (r_off == 30'd1);

  always_comb begin
    w_rd_mux = '0;
    if (w_off == 30'd0) begin
      w_rd_mux = {14'd0, (SATURATE != 0), w_snap_valid, 8'(CNT_W), 8'(N_CH)};
    end else if (w_off == 30'd1) begin
      w_rd_mux = 32'(ovf_out);
    end
    for (int k = 0; k < N_CH; k++) begin
      if (w_off == 30'(k + 2)) w_rd_mux = 32'(w_chval[k]);
    end
  end

  // Transfer is captured in the decode cycle; write side effects fire at the end of the ack cycle.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_hit   <= 1'b0;
      r_ack   <= 1'b0;
      r_rnw   <= 1'b1;
      r_off   <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_hit <= w_hit;
      r_ack <= Sl_xferAck;
      if (w_hit) begin
        r_rnw   <= OPB_RNW;
        r_off   <= w_off;
        r_wdata <= w_wdata[WD_W-1:0];
        r_rdata <= OPB_RNW ? w_rd_mux : '0;
      end
    end
  end

`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
  logic w_snap;
  logic r_snap_valid;

  assign w_snap       = w_ctrl_wr && r_wdata[0];
  assign w_snap_valid = r_snap_valid;

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_snap_valid <= 1'b0;
    else if (w_snap) r_snap_valid <= 1'b1;
  end
`else
  assign w_snap_valid = 1'b0;
`endif

  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      logic [CNT_W-1:0] r_cnt;
      logic             r_ovf;
      logic             w_clr;
      logic             w_at_max_evt;

      assign w_clr        = (w_ctrl_wr && r_wdata[1]) || (w_wr && (r_off == 30'(gi + 2)));
      assign w_at_max_evt = event_in[gi] && (r_cnt == CNT_MAX);

      // Clear wins over a same-cycle event; the lost event never flags overflow.
      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          r_cnt <= '0;
        end else if (w_clr) begin
          r_cnt <= '0;
        end else if (event_in[gi] && !(w_at_max_evt && (SATURATE != 0))) begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end

      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) begin
          r_ovf <= 1'b0;
        end else if (!w_clr && w_at_max_evt) begin
          r_ovf <= 1'b1;
        end else if (w_ovf_wr && r_wdata[gi]) begin
          r_ovf <= 1'b0;
        end
      end

`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
      logic [CNT_W-1:0] r_snap;

      always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
        if (!OPB_Rst_n) r_snap <= '0;
        else if (w_snap) r_snap <= r_cnt;
      end

      assign w_chval[gi] = r_snap;
`else
      assign w_chval[gi] = r_cnt;
`endif

      assign ovf_out[gi] = r_ovf;
    end
  endgenerate

endmodule

// File: tb/tb_opb_event_counter_bank.sv
// Bench for opb_event_counter_bank: three instances (32-bit wrap, 4-bit wrap, 4-bit saturate)
// share one OPB bus and event vector; a spec-level model is compared every cycle.
`timescale 1ns/1ps
module tb_opb_event_counter_bank;
  localparam int NI = 3;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [0:31] abus = '0;
  logic [0:31] dbus_in = '0;
  logic [0:3]  be = 4'hF;
  logic        rnw = 1'b1;
  logic        sel = 1'b0;
  logic        seq = 1'b0;
  logic [3:0]  ev = '0;

  logic [0:31] db   [NI];
  logic        ack  [NI];
  logic        err  [NI];
  logic        rty  [NI];
  logic        tsup [NI];
  logic [3:0]  ovf  [NI];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    opb_event_counter_bank #(
      .CNT_W    ((gi == 0) ? 32 : 4),
      .SATURATE ((gi == 2) ? 1 : 0)
    ) u_dut (
      .OPB_Clk     (clk),
      .OPB_Rst_n   (rst_n),
      .OPB_ABus    (abus),
      .OPB_BE      (be),
      .OPB_DBus    (dbus_in),
      .OPB_RNW     (rnw),
      .OPB_select  (sel),
      .OPB_seqAddr (seq),
      .Sl_DBus     (db[gi]),
      .Sl_xferAck  (ack[gi]),
      .Sl_errAck   (err[gi]),
      .Sl_retry    (rty[gi]),
      .Sl_toutSup  (tsup[gi]),
      .event_in    (ev),
      .ovf_out     (ovf[gi])
    );
  end

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%08h exp=0x%08h", nm, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int unsigned     cw  [NI] = '{32, 4, 4};
  bit              sat [NI] = '{1'b0, 1'b0, 1'b1};
  longint unsigned m_cnt  [NI][4];
  longint unsigned m_snap [NI][4];
  bit              m_ovf  [NI][4];
  bit              m_sv   [NI];
  bit              e_ack;
  bit [31:0]       e_db [NI];
  bit [31:0]       nd   [NI];
  bit [31:0]       m_addr;
  bit [31:0]       m_d;
  longint unsigned m_off;
  longint unsigned maxv;
  bit              m_hit, m_wr, m_nack, m_clr, m_setov;

  function automatic bit [31:0] model_read(int n, longint unsigned off);
    bit [31:0] v;
    v = '0;
    if (off == 0) begin
      v = 32'(cw[n]) * 256 + 4 + (sat[n] ? 32'h2_0000 : 32'h0);
`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
      if (m_sv[n]) v += 32'h1_0000;
`endif
    end else if (off == 1) begin
      for (int c = 0; c < 4; c++) if (m_ovf[n][c]) v += (32'd1 << c);
    end else if (off >= 2 && off < 6) begin
`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
      v = 32'(m_snap[n][off-2]);
`else
      v = 32'(m_cnt[n][off-2]);
`endif
    end
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_ack = 1'b0;
      for (int n = 0; n < NI; n++) begin
        e_db[n] = '0;
        m_sv[n] = 1'b0;
        for (int c = 0; c < 4; c++) begin
          m_cnt[n][c] = 0; m_snap[n][c] = 0; m_ovf[n][c] = 1'b0;
        end
      end
    end else begin
      m_addr = abus;
      m_d    = dbus_in;
      m_hit  = sel && (m_addr <= 32'h0000_00FF);
      m_off  = longint'(m_addr >> 2);
      m_wr   = e_ack && !rnw;
      m_nack = m_hit && !e_ack;
      for (int n = 0; n < NI; n++) nd[n] = (m_nack && rnw) ? model_read(n, m_off) : 32'h0;
      for (int n = 0; n < NI; n++) begin
        if (m_wr && m_off == 0 && m_d[0]) begin
          m_sv[n] = 1'b1;
          for (int c = 0; c < 4; c++) m_snap[n][c] = m_cnt[n][c];
        end
        maxv = (64'd1 << cw[n]) - 1;
        for (int c = 0; c < 4; c++) begin
          m_clr   = m_wr && ((m_off == 0 && m_d[1]) || m_off == longint'(c + 2));
          m_setov = 1'b0;
          if (m_clr) m_cnt[n][c] = 0;
          else if (ev[c]) begin
            m_setov = (m_cnt[n][c] == maxv);
            if (sat[n]) m_cnt[n][c] = m_setov ? maxv : m_cnt[n][c] + 1;
            else        m_cnt[n][c] = (m_cnt[n][c] + 1) % (maxv + 1);
          end
          if (m_setov) m_ovf[n][c] = 1'b1;
          else if (m_wr && m_off == 1 && m_d[c]) m_ovf[n][c] = 1'b0;
        end
      end
      e_ack = m_nack;
      for (int n = 0; n < NI; n++) e_db[n] = nd[n];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    for (int n = 0; n < NI; n++) begin
      bit [3:0] eo;
      for (int c = 0; c < 4; c++) eo[c] = m_ovf[n][c];
      check($sformatf("ack u%0d", n), 32'(ack[n]), 32'(e_ack));
      check($sformatf("dbus u%0d", n), db[n], e_db[n]);
      check($sformatf("ovf u%0d", n), 32'(ovf[n]), 32'(eo));
      check($sformatf("ties u%0d", n), {29'd0, err[n], rty[n], tsup[n]}, 32'd0);
    end
  end

  // ---------------- stimulus ----------------
  logic [31:0] rd [NI];

  task automatic xfer(input logic r, input logic [31:0] a, input logic [31:0] d,
                      output logic acked, output int lat);
    abus = a; dbus_in = d; rnw = r; sel = 1'b1;
    acked = 1'b0; lat = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack[0] === 1'b1) begin
        acked = 1'b1; lat = i - 1;
        for (int n = 0; n < NI; n++) rd[n] = db[n];
        break;
      end
      @(posedge clk); #1;
    end
    if (acked) begin @(posedge clk); #1; end
    sel = 1'b0; rnw = 1'b1; abus = '0; dbus_in = '0;
  endtask

  task automatic rd_chk(input string nm, input logic [31:0] a,
                        input logic [31:0] e0, input logic [31:0] e1, input logic [31:0] e2);
    logic acked; int lat;
    xfer(1'b1, a, 32'h0, acked, lat);
    check({nm, " acked"}, 32'(acked), 32'd1);
    check({nm, " u0"}, rd[0], e0);
    check({nm, " u1"}, rd[1], e1);
    check({nm, " u2"}, rd[2], e2);
    $display("read  0x%02h -> %0h %0h %0h", a, rd[0], rd[1], rd[2]);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    logic acked; int lat;
    xfer(1'b0, a, d, acked, lat);
    check($sformatf("write 0x%02h acked", a), 32'(acked), 32'd1);
    $display("write 0x%02h <- 0x%0h", a, d);
  endtask

  initial begin
    logic acked; int lat;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    xfer(1'b1, 32'h0, 32'h0, acked, lat);
    check("ctrl latency", 32'(lat), 32'd1);
    @(negedge clk);
    check("dbus idle", db[0], 32'h0);
    @(posedge clk); #1;
    rd_chk("ctrl", 32'h00, 32'h2004, 32'h0404, 32'h2_0404);

    for (int i = 0; i < 7; i++) begin
      ev = 4'b0100; @(posedge clk); #1;
      ev = 4'b0000; @(posedge clk); #1;
    end
    wr(32'h00, 32'h1);
    rd_chk("ch2 seven", 32'h10, 7, 7, 7);
    rd_chk("ch0 zero", 32'h08, 0, 0, 0);

    ev = 4'b0001;
    repeat (17) @(posedge clk);
    #1 ev = 4'b0000;
    wr(32'h00, 32'h1);
    rd_chk("ch0 seventeen", 32'h08, 17, 1, 15);
    rd_chk("ovf set", 32'h04, 0, 1, 1);
    wr(32'h04, 32'h1);
    rd_chk("ovf w1c", 32'h04, 0, 0, 0);

    ev = 4'b0010;
    repeat (3) @(posedge clk);
    #1;
    wr(32'h0C, 32'hDEAD_BEEF);
`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
    xfer(1'b1, 32'h0C, 32'h0, acked, lat);
    ev = 4'b0000;
    wr(32'h00, 32'h1);
`else
    rd_chk("ch1 after clr", 32'h0C, 0, 0, 0);
    ev = 4'b0000;
`endif
    rd_chk("ch1 recount", 32'h0C, 2, 2, 2);

    wr(32'h08, 32'h0);
    ev = 4'b0001;
    repeat (5) @(posedge clk);
    #1 ev = 4'b0000;
    wr(32'h00, 32'h3);
`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
    rd_chk("snap pre-clear", 32'h08, 5, 5, 5);
`else
    rd_chk("live post-clear", 32'h08, 0, 0, 0);
`endif
    wr(32'h00, 32'h1);
    rd_chk("snap after clear", 32'h08, 0, 0, 0);

    xfer(1'b1, 32'h0000_0103, 32'h0, acked, lat);
    check("out of window no ack", 32'(acked), 32'd0);
    $display("read  0x103 -> acked=%0d", acked);

    ev = 4'b1000;
    repeat (3) @(posedge clk);
    #1 ev = 4'b0000;
    abus = 32'h14; rnw = 1'b1; sel = 1'b1;
    @(posedge clk); #1;
    check("ack before reset", 32'(ack[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("ack in reset", 32'(ack[0]), 32'd0);
    check("dbus in reset", db[0], 32'h0);
    check("ovf in reset", 32'(ovf[1]), 32'h0);
    $display("reset mid-read ack=%0d", ack[0]);
    sel = 1'b0; abus = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    wr(32'h00, 32'h1);
    rd_chk("ch3 after reset", 32'h14, 0, 0, 0);
    wr(32'h00, 32'h0);
    rd_chk("ctrl after reset", 32'h00,
`ifdef OPB_EVENT_COUNTER_BANK_SNAPSHOT_EN
           32'h1_2004, 32'h1_0404, 32'h3_0404);
`else
           32'h2004, 32'h0404, 32'h2_0404);
`endif

    @(posedge clk); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
